// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM arbiter and the control unit.
package ram_arb_pkg;

    localparam int AW_DEF   = 16;
    localparam int DW_DEF   = 16;
    localparam int LENW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPU,
        TAG_VID
    } tag_t;

endpackage

// File: rtl/vid_burst_ctr.sv
// Burst address pointer and remaining-word counter for the video fetcher.
module vid_burst_ctr #(
    parameter int AW   = 16,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            load,
    input  logic [AW-1:0]   base,
    input  logic [LENW-1:0] len,
    input  logic            step,
    output logic [AW-1:0]   addr_ptr,
    output logic            last
);

    logic [AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0] rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = base;
            rem_d  = len;
        end else if (step) begin
            // Natural wrap at 2^AW is intended.
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - LENW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_ptr = addr_q;
    assign last     = (rem_q == LENW'(1));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU load/store path has priority, video burst
// fetcher gets a slot after MAX_STREAK consecutive CPU grants.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int LENW       = LENW_DEF,
    parameter int MAX_STREAK = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic            cpu_stall,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_rvalid,
    input  logic            vid_start,
    input  logic [AW-1:0]   vid_base,
    input  logic [LENW-1:0] vid_len,
    output logic            vid_busy,
    output logic [DW-1:0]   vid_data,
    output logic            vid_valid,
    output logic            vid_done,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_we,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    state_t          state_q, state_d;
    tag_t            tag_q, tag_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            done_q, done_d;
    logic [AW-1:0]   addr_hold_q, addr_hold_d;
    logic [DW-1:0]   wdata_hold_q, wdata_hold_d;

    logic            cpu_grant, vid_grant, burst_load, burst_last;
    logic [AW-1:0]   addr_ptr;

    assign cpu_grant  = cpu_req & ~((state_q == BURST) & (streak_q == SW'(MAX_STREAK)));
    assign vid_grant  = (state_q == BURST) & ~cpu_grant;
    assign burst_load = (state_q == IDLE) & vid_start;

    vid_burst_ctr #(
        .AW   (AW),
        .LENW (LENW)
    ) u_ctr (
        .clk      (CLK),
        .srst     (RST),
        .load     (burst_load),
        .base     (vid_base),
        .len      (vid_len),
        .step     (vid_grant),
        .addr_ptr (addr_ptr),
        .last     (burst_last)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vid_start) begin
                    state_d = (vid_len == '0) ? DRAIN : BURST;
                end
            end
            BURST: begin
                if (vid_grant && burst_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (burst_load || vid_grant) begin
            streak_d = '0;
        end else if (cpu_grant && (state_q == BURST)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (cpu_grant && !cpu_we) begin
            tag_d = TAG_CPU;
        end else if (vid_grant) begin
            tag_d = TAG_VID;
        end
    end

    // Idle cycles keep the pins steady to avoid needless RAM toggling.
    always_comb begin
        ram_addr  = addr_hold_q;
        ram_wdata = wdata_hold_q;
        ram_we    = 1'b0;
        if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end else if (vid_grant) begin
            ram_addr  = addr_ptr;
        end
        addr_hold_d  = ram_addr;
        wdata_hold_d = ram_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            tag_q        <= TAG_NONE;
            streak_q     <= '0;
            done_q       <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            streak_q     <= streak_d;
            done_q       <= done_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_grant;
    assign cpu_rvalid = (tag_q == TAG_CPU);
    assign cpu_rdata  = ram_rdata;
    assign vid_valid  = (tag_q == TAG_VID);
    assign vid_data   = ram_rdata;
    assign vid_done   = done_q;
    assign vid_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vid_start;
    logic [15:0] vid_base;
    logic [7:0]  vid_len;
    logic        vid_busy, vid_valid, vid_done;
    logic [15:0] vid_data;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

    logic [15:0] mem [0:65535];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int vq[$];
    int vc[$];
    int dc[$];
    int sc[$];
    int we_cnt;

    always #5 CLK = ~CLK;

    ram_arbiter #(.AW(16), .DW(16), .LENW(8), .MAX_STREAK(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vid_start  (vid_start),
        .vid_base   (vid_base),
        .vid_len    (vid_len),
        .vid_busy   (vid_busy),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .vid_done   (vid_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge CLK);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // Cycle 0 carries the start pulse; events are logged by cycle index.
    task automatic run_burst(input logic [15:0] base, input logic [7:0] len,
                             input bit cpu_hold, input int restart_at, input int ncyc);
        vq.delete(); vc.delete(); dc.delete(); sc.delete(); we_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            vid_start = (c == 0) || (c == restart_at);
            vid_base  = (c == 0) ? base : base + 16'h0200;
            vid_len   = (c == 0) ? len : len + 8'd1;
            cpu_req   = cpu_hold; cpu_we = 1'b0; cpu_addr = 16'h0000;
            #1;
            if (vid_valid) begin vq.push_back(int'(vid_data)); vc.push_back(c); end
            if (vid_done)  dc.push_back(c);
            if (cpu_stall) sc.push_back(c);
            if (ram_we)    we_cnt++;
        end
        @(negedge CLK);
        vid_start = 1'b0; cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } cpu_vec_t;

    cpu_vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev_rd;
        logic [15:0] prev_exp;

        RST = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_start = 0; vid_base = 0; vid_len = 0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vid_valid",  vid_valid, 0);
        chk("rst_vid_done",   vid_done, 0);
        chk("rst_vid_busy",   vid_busy, 0);
        chk("rst_ram_we",     ram_we, 0);
        chk("rst_ram_addr",   ram_addr, 0);
        RST = 1'b0;

        // CPU-only traffic, burst idle.
        vecs[0] = '{1'b1, 16'h0400, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0400, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h0401, 16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 16'h0402, 16'h5678, 16'h0000};
        vecs[4] = '{1'b0, 16'h0401, 16'h0000, 16'h1234};
        vecs[5] = '{1'b0, 16'h0402, 16'h0000, 16'h5678};
        vecs[6] = '{1'b0, 16'h0400, 16'h0000, 16'hBEEF};
        prev_rd = 1'b0; prev_exp = 16'h0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("cpu_stall[%0d]", i), cpu_stall, 0);
            chk($sformatf("cpu_ram_we[%0d]", i), ram_we, vecs[i].we);
            chk($sformatf("cpu_ram_addr[%0d]", i), ram_addr, vecs[i].addr);
            chk($sformatf("cpu_rvalid[%0d]", i), cpu_rvalid, prev_rd);
            if (prev_rd) chk($sformatf("cpu_rdata[%0d]", i), cpu_rdata, prev_exp);
            prev_rd = ~vecs[i].we; prev_exp = vecs[i].exp_rdata;
        end
        @(negedge CLK);
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk("cpu_rvalid_last", cpu_rvalid, 1);
        chk("cpu_rdata_last", cpu_rdata, 16'hBEEF);
        chk("cpu_stall_noreq", cpu_stall, 0);

        // Preload burst and wrap data through the CPU port.
        cpu_write(16'h0800, 16'h0011); cpu_write(16'h0801, 16'h0022);
        cpu_write(16'h0802, 16'h0033); cpu_write(16'h0803, 16'h0044);
        cpu_write(16'h0804, 16'h0055); cpu_write(16'h0805, 16'h0066);
        cpu_write(16'h0900, 16'h00A1); cpu_write(16'h0901, 16'h00A2);
        cpu_write(16'h0902, 16'h00A3);
        cpu_write(16'hFFFE, 16'h00E0); cpu_write(16'hFFFF, 16'h00E1);
        cpu_write(16'h0000, 16'h00E2);

        // Plain burst, CPU idle.
        run_burst(16'h0800, 8'd4, 1'b0, -1, 10);
        chk("b4_nvalid", vq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b4_data[%0d]", i), qget(vq, i), 32'h11 * (i + 1));
            chk($sformatf("b4_vcyc[%0d]", i), qget(vc, i), 2 + i);
        end
        chk("b4_ndone", dc.size(), 1);
        chk("b4_done_cyc", qget(dc, 0), 6);

        // CPU hammering: fetcher gets every 5th cycle.
        run_burst(16'h0900, 8'd3, 1'b1, -1, 22);
        chk("st_nstall", sc.size(), 3);
        chk("st_nvalid", vq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("st_stall_cyc[%0d]", i), qget(sc, i), 5 + 5 * i);
            chk($sformatf("st_vcyc[%0d]", i), qget(vc, i), 6 + 5 * i);
            chk($sformatf("st_data[%0d]", i), qget(vq, i), 32'hA1 + i);
        end
        chk("st_done_cyc", qget(dc, 0), 17);

        // Address wrap.
        run_burst(16'hFFFE, 8'd3, 1'b0, -1, 8);
        chk("wr_nvalid", vq.size(), 3);
        chk("wr_data0", qget(vq, 0), 32'hE0);
        chk("wr_data1", qget(vq, 1), 32'hE1);
        chk("wr_data2", qget(vq, 2), 32'hE2);
        chk("wr_done_cyc", qget(dc, 0), 5);

        // Zero-length burst.
        run_burst(16'h0800, 8'd0, 1'b0, -1, 6);
        chk("l0_nvalid", vq.size(), 0);
        chk("l0_we_cnt", we_cnt, 0);
        chk("l0_ndone", dc.size(), 1);
        chk("l0_done_cyc", qget(dc, 0), 2);

        // Restart while busy must be ignored.
        run_burst(16'h0800, 8'd4, 1'b0, 2, 12);
        chk("rs_nvalid", vq.size(), 4);
        chk("rs_data0", qget(vq, 0), 32'h11);
        chk("rs_data3", qget(vq, 3), 32'h44);
        chk("rs_ndone", dc.size(), 1);
        chk("rs_done_cyc", qget(dc, 0), 6);

        // Reset after two of six words.
        begin
            int stray;
            stray = 0;
            @(negedge CLK);
            vid_start = 1'b1; vid_base = 16'h0800; vid_len = 8'd6;
            @(negedge CLK);
            vid_start = 1'b0;
            @(negedge CLK); #1;
            chk("rr_valid_w1", vid_valid, 1);
            chk("rr_data_w1", vid_data, 16'h0011);
            @(negedge CLK);
            RST = 1'b1;
            #1;
            chk("rr_data_w2", vid_data, 16'h0022);
            @(negedge CLK);
            RST = 1'b0;
            #1;
            chk("rr_busy_after", vid_busy, 0);
            chk("rr_valid_after", vid_valid, 0);
            for (int c = 0; c < 12; c++) begin
                @(negedge CLK); #1;
                if (vid_valid || vid_done || vid_busy) stray++;
            end
            chk("rr_no_activity", stray, 0);
        end
        run_burst(16'h0800, 8'd4, 1'b0, -1, 10);
        chk("rr_fresh_nvalid", vq.size(), 4);
        chk("rr_fresh_data3", qget(vq, 3), 32'h44);
        chk("rr_fresh_done_cyc", qget(dc, 0), 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
